goals_oscillator: RTL and testbench

- Parametrised successor of the two-goal vertical mover: drives NUM_CH goal/obstacle channels that bounce between Y_MIN and Y_MAX once per frame.
- Level-selected speed, exact clamping at the bounds, freeze and recenter controls, and bounce event pulses.
- Sits between the level controller and the goal drawing/collision blocks.
- Even channels start moving up (Y decreasing); odd channels start moving down, mirrored.

---
 rtl/goals_if.sv | 24 ++
 rtl/goals_oscillator.sv | 75 +++++++
 tb/tb_goals_oscillator.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/goals_if.sv
// goals_if: frame controls in, goal positions/directions/bounce events out
interface goals_if #(
    parameter int NUM_CH = 2,
    parameter int WIDTH  = 11
);
    logic                      startOfFrame;
    logic [1:0]                Level;
    logic                      freeze;
    logic                      recenter;
    logic [NUM_CH*WIDTH-1:0]   topLeftY;
    logic [NUM_CH*WIDTH-1:0]   firstY;
    logic [NUM_CH*WIDTH-1:0]   secondY;
    logic [NUM_CH-1:0]         dir;
    logic [NUM_CH-1:0]         bounce;
    logic                      recenter_pending;
    modport master (
        output startOfFrame, Level, freeze, recenter,
        input  topLeftY, firstY, secondY, dir, bounce, recenter_pending
    );
    modport slave (
        input  startOfFrame, Level, freeze, recenter,
        output topLeftY, firstY, secondY, dir, bounce, recenter_pending
    );
endinterface

// File: rtl/goals_oscillator.sv
// goals_oscillator: NUM_CH goal channels bouncing between Y_MIN and Y_MAX once per frame
module goals_oscillator #(
    parameter int NUM_CH     = 2,
    parameter int WIDTH      = 11,
    parameter int Y_MIN      = 155,
    parameter int Y_MAX      = 255,
    parameter int Y_INIT     = 205,
    parameter int GOAL_SPAN  = 64,
    parameter int SPEED_SLOW = 1,
    parameter int SPEED_FAST = 3
) (
    input logic   clk,
    input logic   resetN,
    goals_if.slave bus
);
    typedef logic signed [WIDTH:0] ext_t;
    function automatic logic [NUM_CH-1:0] init_dir();
        for (int i = 0; i < NUM_CH; i++) init_dir[i] = 1'(i % 2);
    endfunction
    localparam logic [NUM_CH-1:0] INIT_DIR = init_dir();
    localparam ext_t LO = ext_t'(Y_MIN);
    localparam ext_t HI = ext_t'(Y_MAX);
    logic signed [WIDTH-1:0] pos_q [NUM_CH];
    logic signed [WIDTH-1:0] pos_d [NUM_CH];
    logic [NUM_CH-1:0] dir_q, dir_d, bounce_q, bounce_d;
    logic pend_q, pend_d, apply;
    ext_t s, nxt;
    always_comb begin
        apply    = bus.startOfFrame && (pend_q || bus.recenter);
        pend_d   = bus.startOfFrame ? 1'b0 : (pend_q || bus.recenter);
        s        = bus.Level[0] ? ext_t'(SPEED_FAST) : ext_t'(SPEED_SLOW);
        pos_d    = pos_q;
        dir_d    = dir_q;
        bounce_d = '0;
        nxt      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            // one extra bit keeps pos +/- s from wrapping before the bound test
            nxt = dir_q[i] ? $signed({pos_q[i][WIDTH-1], pos_q[i]}) + s
                           : $signed({pos_q[i][WIDTH-1], pos_q[i]}) - s;
            if (apply) begin
                pos_d[i] = WIDTH'(Y_INIT);
                dir_d[i] = INIT_DIR[i];
            end else if (bus.startOfFrame && !bus.freeze && bus.Level[1]) begin
                if (dir_q[i] ? nxt >= HI : nxt <= LO) begin
                    pos_d[i]    = dir_q[i] ? WIDTH'(Y_MAX) : WIDTH'(Y_MIN);
                    dir_d[i]    = ~dir_q[i];
                    bounce_d[i] = 1'b1;
                end else begin
                    pos_d[i] = nxt[WIDTH-1:0];
                end
            end
        end
    end
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < NUM_CH; i++) pos_q[i] <= WIDTH'(Y_INIT);
            dir_q    <= INIT_DIR;
            bounce_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            pos_q    <= pos_d;
            dir_q    <= dir_d;
            bounce_q <= bounce_d;
            pend_q   <= pend_d;
        end
    end
    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign bus.topLeftY[g*WIDTH +: WIDTH] = pos_q[g];
        assign bus.secondY[g*WIDTH +: WIDTH]  = pos_q[g] + WIDTH'(GOAL_SPAN);
    end
    assign bus.firstY           = bus.topLeftY;
    assign bus.dir              = dir_q;
    assign bus.bounce           = bounce_q;
    assign bus.recenter_pending = pend_q;
endmodule

// File: tb/tb_goals_oscillator.sv
// tb_goals_oscillator: integer reference model checked every cycle, plus directed literal checks
module tb_goals_oscillator;
    localparam int N = 2, W = 11;
    localparam int YMIN = 155, YMAX = 255, YINIT = 205, SPAN = 64;
    logic clk = 1'b0, resetN = 1'b0;
    int errors = 0, checks = 0;
    bit run = 1'b0;
    int  m_pos [N];
    bit  m_dir [N];
    bit  m_b   [N];
    bit  m_pend;
    goals_if #(.NUM_CH(N), .WIDTH(W)) bus ();
    goals_oscillator #(.NUM_CH(N), .WIDTH(W)) dut (.clk(clk), .resetN(resetN), .bus(bus));
    always #5 clk = ~clk;

    function automatic int ch(input logic [N*W-1:0] v, input int i);
        logic signed [W-1:0] x;
        x = v[i*W +: W];
        return int'(x);
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference: integer positions stepped by the speed, clamped at the bounds
    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            for (int i = 0; i < N; i++) begin
                m_pos[i] <= YINIT;
                m_dir[i] <= bit'(i % 2);
                m_b[i]   <= 1'b0;
            end
            m_pend <= 1'b0;
        end else begin
            m_pend <= bus.startOfFrame ? 1'b0 : (m_pend | bus.recenter);
            for (int i = 0; i < N; i++) begin
                int sp, p;
                sp = (bus.Level == 2'd3) ? 3 : 1;
                p  = m_dir[i] ? m_pos[i] + sp : m_pos[i] - sp;
                m_b[i] <= 1'b0;
                if (bus.startOfFrame && (m_pend || bus.recenter)) begin
                    m_pos[i] <= YINIT;
                    m_dir[i] <= bit'(i % 2);
                end else if (bus.startOfFrame && !bus.freeze && bus.Level >= 2'd2) begin
                    if (!m_dir[i] && p <= YMIN) begin
                        m_pos[i] <= YMIN; m_dir[i] <= 1'b1; m_b[i] <= 1'b1;
                    end else if (m_dir[i] && p >= YMAX) begin
                        m_pos[i] <= YMAX; m_dir[i] <= 1'b0; m_b[i] <= 1'b1;
                    end else begin
                        m_pos[i] <= p;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (run && resetN) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("model topLeftY[%0d]", i), ch(bus.topLeftY, i), m_pos[i]);
                chk($sformatf("model firstY[%0d]", i),   ch(bus.firstY, i),   m_pos[i]);
                chk($sformatf("model secondY[%0d]", i),  ch(bus.secondY, i),  m_pos[i] + SPAN);
                chk($sformatf("model dir[%0d]", i),      int'(bus.dir[i]),    int'(m_dir[i]));
                chk($sformatf("model bounce[%0d]", i),   int'(bus.bounce[i]), int'(m_b[i]));
            end
            chk("model pending", int'(bus.recenter_pending), int'(m_pend));
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            bus.startOfFrame = 1'b1;
            @(negedge clk);
            bus.startOfFrame = 1'b0;
            @(negedge clk);
        end
    endtask
    task automatic do_reset();
        resetN = 1'b0;
        bus.Level = 2'd0; bus.freeze = 1'b0; bus.recenter = 1'b0; bus.startOfFrame = 1'b0;
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
    endtask
    task automatic pos2(input string name, input int a, input int b);
        chk({name, " ch0"}, ch(bus.topLeftY, 0), a);
        chk({name, " ch1"}, ch(bus.topLeftY, 1), b);
    endtask

    initial begin
        bus.startOfFrame = 1'b0; bus.Level = 2'd0; bus.freeze = 1'b0; bus.recenter = 1'b0;
        @(negedge clk);
        do_reset();
        run = 1'b1;
        pos2("reset pos", 205, 205);
        chk("reset secondY ch0", ch(bus.secondY, 0), 269);
        chk("reset dir", int'(bus.dir), 2);
        chk("reset bounce", int'(bus.bounce), 0);
        // fast speed to the bounds
        bus.Level = 2'd3;
        tick(10);
        pos2("L3 tick10", 175, 235);
        tick(6);
        pos2("L3 tick16", 157, 253);
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        pos2("L3 tick17", 155, 255);
        chk("L3 tick17 dir", int'(bus.dir), 1);
        chk("L3 tick17 bounce", int'(bus.bounce), 3);
        @(negedge clk);
        chk("L3 bounce drop", int'(bus.bounce), 0);
        tick(1);
        pos2("L3 tick18", 158, 252);
        // slow speed lands exactly on the bounds
        do_reset();
        bus.Level = 2'd2;
        tick(49);
        pos2("L2 tick49", 156, 254);
        bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.startOfFrame = 1'b0;
        pos2("L2 tick50", 155, 255);
        chk("L2 tick50 bounce", int'(bus.bounce), 3);
        @(negedge clk);
        bus.Level = 2'd0;
        tick(5);
        pos2("L0 hold", 155, 255);
        chk("L0 hold dir", int'(bus.dir), 1);
        // freeze
        do_reset();
        bus.Level = 2'd3;
        tick(8);
        pos2("pre freeze", 181, 229);
        bus.freeze = 1'b1;
        tick(4);
        pos2("frozen", 181, 229);
        bus.freeze = 1'b0;
        tick(1);
        pos2("unfrozen", 178, 232);
        // recenter during freeze
        bus.freeze = 1'b1;
        tick(2);
        bus.recenter = 1'b1;
        @(negedge clk);
        bus.recenter = 1'b0;
        chk("pending set", int'(bus.recenter_pending), 1);
        repeat (3) @(negedge clk);
        chk("pending held", int'(bus.recenter_pending), 1);
        tick(1);
        pos2("recentered", 205, 205);
        chk("recentered dir", int'(bus.dir), 2);
        chk("pending cleared", int'(bus.recenter_pending), 0);
        // recenter coincident with a tick
        bus.freeze = 1'b0;
        tick(3);
        bus.recenter = 1'b1; bus.startOfFrame = 1'b1;
        @(negedge clk);
        bus.recenter = 1'b0; bus.startOfFrame = 1'b0;
        pos2("coincident", 205, 205);
        chk("coincident pending", int'(bus.recenter_pending), 0);
        // async reset mid-motion discards a pending recenter
        tick(3);
        pos2("pre reset", 196, 214);
        bus.recenter = 1'b1;
        @(negedge clk);
        bus.recenter = 1'b0;
        #2 resetN = 1'b0;
        #1;
        pos2("async reset", 205, 205);
        chk("async reset secondY ch1", ch(bus.secondY, 1), 269);
        chk("async reset pending", int'(bus.recenter_pending), 0);
        @(negedge clk);
        resetN = 1'b1;
        @(negedge clk);
        chk("post reset pending", int'(bus.recenter_pending), 0);
        tick(2);
        pos2("post reset move", 199, 211);
        run = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
